// File: rtl/store_buffer.sv
// Posted-write store buffer between the datapath load/store port and the data RAM.
// Stores retire into a small FIFO; loads bypass it unless they overlap a buffered store.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  input  logic                   fence,
  output logic                   stall,
  output logic                   misaligned,
  output logic [31:0]            rdata,
  output logic [$clog2(DEPTH):0] buf_count,
  output logic                   buf_empty,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [1:0]             mem_data_size,
  output logic                   mem_unsigned,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {NORMAL, FENCING} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  logic [ADDR_W-1:0] entryAddr_q [DEPTH];
  logic [1:0]        entrySize_q [DEPTH];
  logic [31:0]       entryData_q [DEPTH];

  logic [1:0]        reqSize;
  logic [3:0]        reqMask;
  logic              reqMisaligned;
  logic [PTR_W-1:0]  entryOffset [DEPTH];
  logic [DEPTH-1:0]  entryValid;
  logic [DEPTH-1:0]  entryHit;
  logic              loadOverlap;
  logic              fenceActive;
  logic              loadGrant;
  logic              push;
  logic              pop;

  function automatic logic [3:0] byteMask(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      2'b00:   byteMask = 4'b0001 << lo;
      2'b01:   byteMask = 4'b0011 << lo;
      default: byteMask = 4'b1111;
    endcase
  endfunction

  // Size 11 is carried as a word everywhere, including into the FIFO and onto the RAM port.
  always_comb begin
    reqSize = (req_size == 2'b11) ? 2'b10 : req_size;
    reqMask = byteMask(req_addr[1:0], reqSize);
    case (reqSize)
      2'b00:   reqMisaligned = 1'b0;
      2'b01:   reqMisaligned = req_addr[0];
      default: reqMisaligned = |req_addr[1:0];
    endcase
  end

  // An entry is live when its distance from head (modulo DEPTH) is below the occupancy.
  always_comb begin
    entryValid = '0;
    entryHit   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryOffset[i] = PTR_W'(i) - head_q;
      entryValid[i]  = {1'b0, entryOffset[i]} < count_q;
      entryHit[i]    = entryValid[i]
                       && (entryAddr_q[i][ADDR_W-1:2] == req_addr[ADDR_W-1:2])
                       && (|(byteMask(entryAddr_q[i][1:0], entrySize_q[i]) & reqMask));
    end
    loadOverlap = |entryHit;
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fenceActive   = 1'b0;
    loadGrant     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    stall         = 1'b0;
    misaligned    = 1'b0;
    rdata         = '0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_data_size = '0;
    mem_unsigned  = 1'b0;
    mem_wdata     = '0;

    if (!reset) begin
      // A fence pulse applies in its own cycle, ahead of any request issued alongside it.
      fenceActive = ((state_q == FENCING) || fence) && (count_q != '0);
      misaligned  = req_valid && reqMisaligned;

      if (req_valid && !reqMisaligned && !fenceActive) begin
        if (req_we) push      = (count_q != FULL_COUNT);
        else        loadGrant = !loadOverlap;
      end

      pop   = !loadGrant && (count_q != '0);
      stall = req_valid && !reqMisaligned && !loadGrant && !push;

      if (loadGrant) begin
        mem_addr      = req_addr;
        mem_data_size = reqSize;
        mem_unsigned  = req_unsigned;
        rdata         = mem_rdata;
      end else if (pop) begin
        mem_we        = 1'b1;
        mem_addr      = entryAddr_q[head_q];
        mem_data_size = entrySize_q[head_q];
        mem_wdata     = entryData_q[head_q];
      end

      head_d  = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      state_d = (fenceActive && (count_d != '0)) ? FENCING : NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr_q[tail_q] <= req_addr;
      entrySize_q[tail_q] <= reqSize;
      entryData_q[tail_q] <= req_wdata;
    end
  end

  assign buf_count = count_q;
  assign buf_empty = (count_q == '0);

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle datapath's load/store port and the byte-addressable data RAM. Stores retire into a DEPTH-entry FIFO in one cycle and drain to the RAM whenever a load is not using its single port. Loads read the RAM directly unless they overlap a buffered store, in which case the datapath is stalled until the conflicting entries have drained. The block also flags misaligned accesses and supports a fence that empties the buffer.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- ADDR_W, 32, byte-address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  datapath issues a memory access this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_wdata  in  32  store data, little-endian, LSB aligned
- fence  in  1  one-cycle pulse: drain all buffered stores before accepting any request
- stall  out  1  hold PC/request; the request is not performed this cycle
- misaligned  out  1  request is misaligned; not performed
- rdata  out  32  load result, valid when a load is granted
- buf_count  out  $clog2(DEPTH)+1  number of occupied entries
- buf_empty  out  1  buf_count == 0
- mem_we, mem_addr[ADDR_W-1:0], mem_data_size[1:0], mem_unsigned, mem_wdata[31:0]  out  RAM port
- mem_rdata  in  32  RAM combinational read data, already extended per size/unsigned

## Operation
- Entry fields: addr, size, wdata. The FIFO uses head/tail pointers that wrap modulo DEPTH, plus a count.
- Alignment: word requires addr[1:0]==0; halfword requires addr[0]==0; byte is always aligned. Misaligned with req_valid gives misaligned=1 and stall=0, with no enqueue and no RAM access.
- Byte mask: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111. A load overlaps an entry when addr[ADDR_W-1:2] is equal and the masks intersect. Overlap is checked against all valid entries.
- FSM states:
  - NORMAL: requests are serviced.
  - FENCING: entered on fence=1. While in FENCING, stall=1 for every valid request and the buffer drains. Return to NORMAL in the cycle after count reaches 0. A fence with an empty buffer causes no stall.
- Store in NORMAL:
  - If count<DEPTH, enqueue at the clock edge with stall=0.
  - If count==DEPTH, stall=1 even if a drain occurs in the same cycle. The store is accepted on the next cycle.
- Load in NORMAL:
  - No overlap: the RAM port carries the load (mem_we=0, mem_addr/size/unsigned taken from req), rdata=mem_rdata, stall=0. No drain occurs this cycle.
  - Overlap: stall=1 and the port drains the head entry.
- Drain: in any cycle where the port is not granted to a load and count>0, drive mem_we=1 with the head entry's addr/size/wdata (mem_unsigned=0). Pop at the clock edge.
- Simultaneous store enqueue and drain pop leaves count unchanged. Both pointers advance.
- Idle cycles (req_valid=0) drain.
- rdata=0 when no load is granted.

## Timing
- Load latency: 0 cycles (combinational through the RAM). A store retires in its issue cycle.
- A drained store is written to the RAM at the clock edge ending its drain cycle.
- Overlap stall lasts until the youngest conflicting entry has been written. A load is granted in the cycle after that write, so the load sees the new data.
- While reset=1:
  - mem_we=0, stall=0, misaligned=0, rdata=0.
  - At the edge: count=0, head=tail=0, state=NORMAL, buf_empty=1.
- Reset mid-operation discards buffered stores; they are never written.
- fence and a store issued in the same cycle: the fence takes effect first, so the store stalls.

## Test plan
- Store word 0xDEADBEEF @0x10, 3 idle cycles, then LW @0x10 → stall=0 on the store; mem_we=1 with addr 0x10 in the next cycle; the load returns 0xDEADBEEF with stall=0.
- SB 0x80 @0x21 then immediately LB @0x21 (no idle) → stall=1 for 1 cycle while the entry drains; then rdata=0xFFFFFF80. LBU @0x20 with no pending store → not stalled.
- 5 back-to-back SW with DEPTH=4 while a load stream blocks the port → the first 4 are accepted (buf_count=4); the 5th stalls until a drain; FIFO order is preserved at the RAM and the pointers wrap.
- LW @0x13, LH @0x11, SW @0x02 → misaligned=1 each time, stall=0, mem_we=0, buf_count unchanged.
- Buffer holding 3 stores, pulse fence, issue LW to an unrelated address → stall=1 for 3 cycles; 3 RAM writes occur; the load is granted on cycle 4.
- Buffer holding 2 stores, assert reset for 1 cycle → buf_count=0, buf_empty=1, and no mem_we pulses follow.
